// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle LEGv8 control FSM.
// Holds the FSM state enum, the decoded instruction classes, opcode
// constants, ALU function codes, pc_sel encodings and FLAGS bit indices.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [2:0] {
        C_ALU,
        C_LOAD,
        C_STORE,
        C_B,
        C_BGT,
        C_BR,
        C_NOP,
        C_ILL
    } iclass_e;

    // 11-bit opcodes, instr[31:21]
    localparam logic [10:0] OP_ADD    = 11'h458;
    localparam logic [10:0] OP_SUB    = 11'h658;
    localparam logic [10:0] OP_AND    = 11'h450;
    localparam logic [10:0] OP_ORR    = 11'h550;
    localparam logic [10:0] OP_EOR    = 11'h650;
    localparam logic [10:0] OP_LSL    = 11'h69B;
    localparam logic [10:0] OP_LDURSW = 11'h5C4;
    localparam logic [10:0] OP_STURW  = 11'h5C0;
    localparam logic [10:0] OP_BR     = 11'h6B0;

    // Prefix-decoded branches
    localparam logic [5:0]  B_PFX     = 6'b000101;   // instr[31:26]
    localparam logic [7:0]  BGT_PFX   = 8'b01010100; // instr[31:24]
    localparam logic [4:0]  COND_GT   = 5'h0C;       // instr[4:0]

    // ALU function select
    localparam logic [2:0]  ALU_PASS  = 3'b000;
    localparam logic [2:0]  ALU_ADD   = 3'b001;
    localparam logic [2:0]  ALU_SUB   = 3'b010;
    localparam logic [2:0]  ALU_AND   = 3'b011;
    localparam logic [2:0]  ALU_ORR   = 3'b100;
    localparam logic [2:0]  ALU_EOR   = 3'b101;
    localparam logic [2:0]  ALU_LSL   = 3'b110;

    // PC update source
    localparam logic [1:0]  PC_SEQ    = 2'd0; // PC + 4
    localparam logic [1:0]  PC_REL    = 2'd1; // PC + branch_offset
    localparam logic [1:0]  PC_REG    = 2'd2; // register (read1 data)

    // FLAGS = {N,Z,V,C}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/multicycle_control_instr_field_decode.sv
// Combinational instruction field decoder.
// Ports:
//   instr_i          32-bit instruction word
//   cls_o            instruction class (ALU, load, store, branch kinds, NOP, illegal)
//   alu_fn_o         ALU function for ALU ops; ADD for address generation
//   constant_o       zero-extended shamt, or sign-extended DT_address for load/store
//   branch_offset_o  sign-extended imm26 (B) or imm19 (BGT), shifted left by 2
//   illegal_o        opcode is not decodable
module instr_field_decode
    import multicycle_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       instr_i,
    output iclass_e           cls_o,
    output logic [2:0]        alu_fn_o,
    output logic [DATA_W-1:0] constant_o,
    output logic [DATA_W-1:0] branch_offset_o,
    output logic              illegal_o
);

    logic [10:0] op;
    assign op = instr_i[31:21];

    always_comb begin
        cls_o    = C_ILL;
        alu_fn_o = ALU_PASS;
        if (instr_i == '0) begin
            cls_o = C_NOP;
        end else begin
            case (op)
                OP_ADD:    begin cls_o = C_ALU;   alu_fn_o = ALU_ADD; end
                OP_SUB:    begin cls_o = C_ALU;   alu_fn_o = ALU_SUB; end
                OP_AND:    begin cls_o = C_ALU;   alu_fn_o = ALU_AND; end
                OP_ORR:    begin cls_o = C_ALU;   alu_fn_o = ALU_ORR; end
                OP_EOR:    begin cls_o = C_ALU;   alu_fn_o = ALU_EOR; end
                OP_LSL:    begin cls_o = C_ALU;   alu_fn_o = ALU_LSL; end
                OP_LDURSW: begin cls_o = C_LOAD;  alu_fn_o = ALU_ADD; end
                OP_STURW:  begin cls_o = C_STORE; alu_fn_o = ALU_ADD; end
                OP_BR:     begin cls_o = C_BR; end
                default: begin
                    // Prefix decodes cannot alias any 11-bit opcode above.
                    if (instr_i[31:26] == B_PFX)
                        cls_o = C_B;
                    else if (instr_i[31:24] == BGT_PFX && instr_i[4:0] == COND_GT)
                        cls_o = C_BGT;
                end
            endcase
        end

        if (cls_o == C_LOAD || cls_o == C_STORE)
            constant_o = {{(DATA_W-9){instr_i[20]}}, instr_i[20:12]};
        else
            constant_o = {{(DATA_W-6){1'b0}}, instr_i[15:10]};

        if (cls_o == C_B)
            branch_offset_o = {{(DATA_W-28){instr_i[25]}}, instr_i[25:0], 2'b00};
        else if (cls_o == C_BGT)
            branch_offset_o = {{(DATA_W-21){instr_i[23]}}, instr_i[23:5], 2'b00};
        else
            branch_offset_o = '0;
    end

    assign illegal_o = (cls_o == C_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: latches one instruction and sequences
// DECODE, EXEC, MEM and WB, driving regfile/ALU/SRAM/PC controls.
// Every output is a register loaded on the edge that enters the cycle in
// which it is meant to act, so strobes line up with the FSM state they
// belong to (branch pc_en lands in the cycle after EXEC).
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   instr_i/instr_valid_i instruction offer; instr_ack_o pulses on latch
//   FLAGS_i               {N,Z,V,C}, sampled in EXEC for BGT
//   mem_ready_i           SRAM access complete
//   read1/read2/write_addr_o, write_en_o   register file controls
//   alu_function_o, Bselect_o, constant_o ALU / Bus-B controls
//   Dselect_o, SRAM_CS_o, SRAM_write_o, writeToSRAM_o  memory path controls
//   pc_en_o, pc_sel_o, branch_offset_o     PC update command
//   illegal_o, mem_err_o                   one-cycle error pulses
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [31:0]       instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ack_o,
    input  logic [3:0]        FLAGS_i,
    input  logic              mem_ready_i,
    output logic [REG_AW-1:0] read1_addr_o,
    output logic [REG_AW-1:0] read2_addr_o,
    output logic [REG_AW-1:0] write_addr_o,
    output logic              write_en_o,
    output logic [2:0]        alu_function_o,
    output logic              Bselect_o,
    output logic [DATA_W-1:0] constant_o,
    output logic              Dselect_o,
    output logic              SRAM_CS_o,
    output logic              SRAM_write_o,
    output logic              writeToSRAM_o,
    output logic              pc_en_o,
    output logic [1:0]        pc_sel_o,
    output logic [DATA_W-1:0] branch_offset_o,
    output logic              illegal_o,
    output logic              mem_err_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;

    logic              ack_q, ack_d;
    logic [REG_AW-1:0] r1_q, r1_d, r2_q, r2_d, wa_q, wa_d;
    logic              we_q, we_d;
    logic [2:0]        alu_q, alu_d;
    logic              bsel_q, bsel_d;
    logic [DATA_W-1:0] const_q, const_d, boff_q, boff_d;
    logic              dsel_q, dsel_d;
    logic              cs_q, cs_d, sw_q, sw_d, wts_q, wts_d;
    logic              pc_en_q, pc_en_d;
    logic [1:0]        pc_sel_q, pc_sel_d;
    logic              ill_q, ill_d, merr_q, merr_d;

    // In IDLE the decoder looks at the offered word so DECODE-cycle
    // outputs can be registered on the accepting edge.
    logic [31:0]       dec_instr;
    iclass_e           dec_cls;
    logic [2:0]        dec_alu;
    logic [DATA_W-1:0] dec_const, dec_boff;
    logic              dec_ill;
    logic              is_store, bgt_taken;

    assign dec_instr = (state_q == S_IDLE) ? instr_i : instr_q;

    instr_field_decode #(.DATA_W(DATA_W)) u_dec (
        .instr_i         (dec_instr),
        .cls_o           (dec_cls),
        .alu_fn_o        (dec_alu),
        .constant_o      (dec_const),
        .branch_offset_o (dec_boff),
        .illegal_o       (dec_ill)
    );

    assign is_store  = (dec_cls == C_STORE);
    assign bgt_taken = !FLAGS_i[FLAG_Z] && (FLAGS_i[FLAG_N] == FLAGS_i[FLAG_V]);
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        cnt_d    = '0;
        // strobes default low
        ack_d    = 1'b0;
        we_d     = 1'b0;
        pc_en_d  = 1'b0;
        pc_sel_d = PC_SEQ;
        ill_d    = 1'b0;
        merr_d   = 1'b0;
        cs_d     = 1'b0;
        sw_d     = 1'b0;
        wts_d    = 1'b0;
        dsel_d   = 1'b0;
        // datapath selects hold so the ALU result stays valid through WB
        r1_d     = r1_q;
        r2_d     = r2_q;
        wa_d     = wa_q;
        const_d  = const_q;
        boff_d   = boff_q;
        alu_d    = alu_q;
        bsel_d   = bsel_q;

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    state_d = S_DECODE;
                    instr_d = instr_i;
                    ack_d   = 1'b1;
                    r1_d    = instr_i[9:5];
                    r2_d    = is_store ? instr_i[4:0] : instr_i[20:16];
                    wa_d    = instr_i[4:0];
                    const_d = dec_const;
                    boff_d  = dec_boff;
                    alu_d   = ALU_PASS;
                    bsel_d  = 1'b0;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                alu_d   = dec_alu;
                bsel_d  = (dec_cls == C_LOAD) || is_store ||
                          (dec_cls == C_ALU && dec_alu == ALU_LSL);
            end
            S_EXEC: begin
                state_d = S_IDLE;
                unique case (dec_cls)
                    C_ALU: begin
                        state_d = S_WB;
                        we_d    = 1'b1;
                        pc_en_d = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        state_d = S_MEM;
                        cs_d    = 1'b1;
                        sw_d    = is_store;
                        wts_d   = is_store;
                        dsel_d  = !is_store;
                    end
                    C_B:   begin pc_en_d = 1'b1; pc_sel_d = PC_REL; end
                    C_BGT: begin pc_en_d = 1'b1; pc_sel_d = bgt_taken ? PC_REL : PC_SEQ; end
                    C_BR:  begin pc_en_d = 1'b1; pc_sel_d = PC_REG; end
                    default: begin
                        pc_en_d = 1'b1;
                        ill_d   = dec_ill;
                    end
                endcase
            end
            S_MEM: begin
                // ready wins over a coinciding timeout
                if (mem_ready_i) begin
                    pc_en_d = 1'b1;
                    if (is_store) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WB;
                        we_d    = 1'b1;
                        dsel_d  = 1'b1;
                    end
                end else if (cnt_inc == CW'(MEM_TIMEOUT)) begin
                    state_d = S_IDLE;
                    merr_d  = 1'b1;
                    pc_en_d = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    cs_d    = 1'b1;
                    sw_d    = is_store;
                    wts_d   = is_store;
                    dsel_d  = !is_store;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            r1_q     <= '0;
            r2_q     <= '0;
            wa_q     <= '0;
            we_q     <= 1'b0;
            alu_q    <= '0;
            bsel_q   <= 1'b0;
            const_q  <= '0;
            boff_q   <= '0;
            dsel_q   <= 1'b0;
            cs_q     <= 1'b0;
            sw_q     <= 1'b0;
            wts_q    <= 1'b0;
            pc_en_q  <= 1'b0;
            pc_sel_q <= '0;
            ill_q    <= 1'b0;
            merr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            wa_q     <= wa_d;
            we_q     <= we_d;
            alu_q    <= alu_d;
            bsel_q   <= bsel_d;
            const_q  <= const_d;
            boff_q   <= boff_d;
            dsel_q   <= dsel_d;
            cs_q     <= cs_d;
            sw_q     <= sw_d;
            wts_q    <= wts_d;
            pc_en_q  <= pc_en_d;
            pc_sel_q <= pc_sel_d;
            ill_q    <= ill_d;
            merr_q   <= merr_d;
        end
    end

    assign instr_ack_o     = ack_q;
    assign read1_addr_o    = r1_q;
    assign read2_addr_o    = r2_q;
    assign write_addr_o    = wa_q;
    assign write_en_o      = we_q;
    assign alu_function_o  = alu_q;
    assign Bselect_o       = bsel_q;
    assign constant_o      = const_q;
    assign branch_offset_o = boff_q;
    assign Dselect_o       = dsel_q;
    assign SRAM_CS_o       = cs_q;
    assign SRAM_write_o    = sw_q;
    assign writeToSRAM_o   = wts_q;
    assign pc_en_o         = pc_en_q;
    assign pc_sel_o        = pc_sel_q;
    assign illegal_o       = ill_q;
    assign mem_err_o       = merr_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Cycle convention: instr_valid is presented in an IDLE cycle; the
// following cycles are DECODE (ack high), EXEC, then WB/MEM.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [3:0]  flags;
    logic        mem_ready;
    logic [4:0]  read1_addr, read2_addr, write_addr;
    logic        write_en;
    logic [2:0]  alu_function;
    logic        Bselect;
    logic [31:0] constant;
    logic        Dselect, SRAM_CS, SRAM_write, writeToSRAM;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [31:0] branch_offset;
    logic        illegal, mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    wire [93:0] all_out = {instr_ack, read1_addr, read2_addr, write_addr, write_en,
                           alu_function, Bselect, constant, Dselect, SRAM_CS,
                           SRAM_write, writeToSRAM, pc_en, pc_sel, branch_offset,
                           illegal, mem_err};

    multicycle_control #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(15)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .instr_i         (instr),
        .instr_valid_i   (instr_valid),
        .instr_ack_o     (instr_ack),
        .FLAGS_i         (flags),
        .mem_ready_i     (mem_ready),
        .read1_addr_o    (read1_addr),
        .read2_addr_o    (read2_addr),
        .write_addr_o    (write_addr),
        .write_en_o      (write_en),
        .alu_function_o  (alu_function),
        .Bselect_o       (Bselect),
        .constant_o      (constant),
        .Dselect_o       (Dselect),
        .SRAM_CS_o       (SRAM_CS),
        .SRAM_write_o    (SRAM_write),
        .writeToSRAM_o   (writeToSRAM),
        .pc_en_o         (pc_en),
        .pc_sel_o        (pc_sel),
        .branch_offset_o (branch_offset),
        .illegal_o       (illegal),
        .mem_err_o       (mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word in IDLE; returns in the DECODE cycle.
    task automatic issue(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL reset_outputs got %h want 0", all_out);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL idle_outputs got %h want 0", all_out);
        end
    endtask

    task automatic test_add();
        issue(32'h8B02_0023);
        n_cmp++;
        if ({instr_ack, read1_addr, read2_addr, write_addr} !== {1'b1, 5'd1, 5'd2, 5'd3}) begin
            n_bad++; $display("FAIL add_decode got ack=%0b r1=%0d r2=%0d wa=%0d want 1/1/2/3",
                              instr_ack, read1_addr, read2_addr, write_addr);
        end
        tick();
        n_cmp++;
        if ({instr_ack, alu_function, Bselect, write_en} !== {1'b0, 3'b001, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL add_exec got ack=%0b alu=%b bsel=%0b we=%0b want 0/001/0/0",
                              instr_ack, alu_function, Bselect, write_en);
        end
        tick();
        n_cmp++;
        if ({write_en, write_addr, pc_en, pc_sel, alu_function} !== {1'b1, 5'd3, 1'b1, 2'd0, 3'b001}) begin
            n_bad++; $display("FAIL add_wb got we=%0b wa=%0d pc_en=%0b sel=%0d alu=%b want 1/3/1/0/001",
                              write_en, write_addr, pc_en, pc_sel, alu_function);
        end
        tick();
        n_cmp++;
        if ({write_en, pc_en} !== 2'b00) begin
            n_bad++; $display("FAIL add_idle got we=%0b pc_en=%0b want 0/0", write_en, pc_en);
        end
    endtask

    task automatic test_lsl();
        int we_cnt = 0;
        issue(32'hD360_0CA4); // LSL X4, X5, #3
        n_cmp++;
        if ({constant, read1_addr, write_addr} !== {32'd3, 5'd5, 5'd4}) begin
            n_bad++; $display("FAIL lsl_decode got const=%h r1=%0d wa=%0d want 3/5/4",
                              constant, read1_addr, write_addr);
        end
        tick();
        n_cmp++;
        if ({alu_function, Bselect} !== {3'b110, 1'b1}) begin
            n_bad++; $display("FAIL lsl_exec got alu=%b bsel=%0b want 110/1", alu_function, Bselect);
        end
        for (int i = 0; i < 4; i++) begin
            if (write_en) we_cnt++;
            tick();
        end
        n_cmp++;
        if (we_cnt !== 1) begin
            n_bad++; $display("FAIL lsl_we_count got %0d want 1", we_cnt);
        end
    endtask

    task automatic test_alu_ops();
        logic [10:0] ops   [4] = '{11'h658, 11'h450, 11'h550, 11'h650};
        logic [2:0]  codes [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
        for (int i = 0; i < 4; i++) begin
            issue({ops[i], 21'h0_8C25}); // Rm=8, shamt=3? no: fields only matter for addrs
            tick();
            n_cmp++;
            if ({alu_function, Bselect} !== {codes[i], 1'b0}) begin
                n_bad++; $display("FAIL alu_op%0d got alu=%b bsel=%0b want %b/0",
                                  i, alu_function, Bselect, codes[i]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_load();
        int cs_cnt = 0;
        issue(32'hB89F_C047); // LDURSW X7, [X2, #-4]
        n_cmp++;
        if ({constant, read1_addr, write_addr} !== {32'hFFFF_FFFC, 5'd2, 5'd7}) begin
            n_bad++; $display("FAIL ld_decode got const=%h r1=%0d wa=%0d want FFFFFFFC/2/7",
                              constant, read1_addr, write_addr);
        end
        tick();
        n_cmp++;
        if ({alu_function, Bselect, SRAM_CS} !== {3'b001, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL ld_exec got alu=%b bsel=%0b cs=%0b want 001/1/0",
                              alu_function, Bselect, SRAM_CS);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (SRAM_CS && Dselect && !SRAM_write && !write_en) cs_cnt++;
            if (i == 2) mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if (cs_cnt !== 3) begin
            n_bad++; $display("FAIL ld_mem_cycles got %0d want 3", cs_cnt);
        end
        n_cmp++;
        if ({SRAM_CS, Dselect, write_en, write_addr, pc_en, pc_sel} !== {1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 2'd0}) begin
            n_bad++; $display("FAIL ld_wb got cs=%0b dsel=%0b we=%0b wa=%0d pc_en=%0b sel=%0d want 0/1/1/7/1/0",
                              SRAM_CS, Dselect, write_en, write_addr, pc_en, pc_sel);
        end
        tick();
        n_cmp++;
        if ({Dselect, write_en, pc_en} !== 3'b000) begin
            n_bad++; $display("FAIL ld_idle got dsel=%0b we=%0b pc_en=%0b want 0/0/0", Dselect, write_en, pc_en);
        end
    endtask

    task automatic test_store_timeout();
        int sw_cnt = 0;
        int overlap = 0;
        issue(32'hB800_8049); // STURW X9, [X2, #8]
        n_cmp++;
        if ({read2_addr, constant} !== {5'd9, 32'd8}) begin
            n_bad++; $display("FAIL st_decode got r2=%0d const=%h want 9/8", read2_addr, constant);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!SRAM_write) break;
            sw_cnt++;
            if (write_en || !writeToSRAM || !SRAM_CS) overlap++;
        end
        n_cmp++;
        if (sw_cnt !== 15 || overlap !== 0) begin
            n_bad++; $display("FAIL st_mem_cycles got %0d (bad strobes %0d) want 15 (0)", sw_cnt, overlap);
        end
        n_cmp++;
        if ({mem_err, pc_en, pc_sel, SRAM_CS, writeToSRAM, write_en} !== {1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL st_timeout got err=%0b pc_en=%0b sel=%0d cs=%0b wts=%0b we=%0b want 1/1/0/0/0/0",
                              mem_err, pc_en, pc_sel, SRAM_CS, writeToSRAM, write_en);
        end
        tick();
        n_cmp++;
        if ({mem_err, pc_en} !== 2'b00) begin
            n_bad++; $display("FAIL st_after got err=%0b pc_en=%0b want 0/0", mem_err, pc_en);
        end
    endtask

    task automatic test_bgt();
        logic [3:0] fv   [4] = '{4'b0000, 4'b1000, 4'b0100, 4'b1010};
        logic [1:0] want [4] = '{2'd1, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            flags = fv[i];
            issue(32'h5400_00AC); // BGT +5
            n_cmp++;
            if (branch_offset !== 32'd20) begin
                n_bad++; $display("FAIL bgt_offset%0d got %h want 14", i, branch_offset);
            end
            tick();
            tick();
            n_cmp++;
            if ({pc_en, pc_sel, write_en} !== {1'b1, want[i], 1'b0}) begin
                n_bad++; $display("FAIL bgt_flags%0d got pc_en=%0b sel=%0d we=%0b want 1/%0d/0",
                                  i, pc_en, pc_sel, write_en, want[i]);
            end
            tick();
        end
        flags = 4'b0000;
    endtask

    task automatic test_branches();
        logic [31:0] w    [4] = '{32'h17FF_FFFF, 32'hD61F_03C0, 32'h0000_0000, 32'hFFE0_0000};
        logic [1:0]  sel  [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
        logic        ill  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] boff [4] = '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            issue(w[i]);
            n_cmp++;
            if (branch_offset !== boff[i]) begin
                n_bad++; $display("FAIL br%0d_offset got %h want %h", i, branch_offset, boff[i]);
            end
            tick();
            n_cmp++;
            if ({pc_en, illegal} !== 2'b00) begin
                n_bad++; $display("FAIL br%0d_early got pc_en=%0b ill=%0b want 0/0", i, pc_en, illegal);
            end
            tick();
            n_cmp++;
            if ({pc_en, pc_sel, illegal, write_en} !== {1'b1, sel[i], ill[i], 1'b0}) begin
                n_bad++; $display("FAIL br%0d_pc got pc_en=%0b sel=%0d ill=%0b we=%0b want 1/%0d/%0b/0",
                                  i, pc_en, pc_sel, illegal, write_en, sel[i], ill[i]);
            end
            if (i == 1) begin
                n_cmp++;
                if (read1_addr !== 5'd30) begin
                    n_bad++; $display("FAIL br_rn got %0d want 30", read1_addr);
                end
            end
            tick();
            n_cmp++;
            if ({pc_en, illegal} !== 2'b00) begin
                n_bad++; $display("FAIL br%0d_pulse got pc_en=%0b ill=%0b want 0/0", i, pc_en, illegal);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        issue(32'hB800_8049);
        tick();
        tick();
        tick();
        n_cmp++;
        if (SRAM_write !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre got sram_write=%0b want 1", SRAM_write);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL rst_mid got %h want 0", all_out);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++; $display("FAIL rst_after got %h want 0", all_out);
        end
        issue(32'h8B02_0023);
        n_cmp++;
        if (instr_ack !== 1'b1) begin
            n_bad++; $display("FAIL rst_idle_ack got %0b want 1", instr_ack);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        instr       = 32'h8B02_0023;
        instr_valid = 1'b1;
        tick();
        instr = 32'hD360_0CA4; // held offer is ignored until IDLE
        n_cmp++;
        if ({instr_ack, write_addr} !== {1'b1, 5'd3}) begin
            n_bad++; $display("FAIL b2b_first got ack=%0b wa=%0d want 1/3", instr_ack, write_addr);
        end
        tick();
        tick();
        n_cmp++;
        if ({instr_ack, write_en, write_addr} !== {1'b0, 1'b1, 5'd3}) begin
            n_bad++; $display("FAIL b2b_wb got ack=%0b we=%0b wa=%0d want 0/1/3", instr_ack, write_en, write_addr);
        end
        tick();
        n_cmp++;
        if (instr_ack !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle got ack=%0b want 0", instr_ack);
        end
        tick();
        instr_valid = 1'b0;
        n_cmp++;
        if ({instr_ack, write_addr, constant} !== {1'b1, 5'd4, 32'd3}) begin
            n_bad++; $display("FAIL b2b_second got ack=%0b wa=%0d const=%h want 1/4/3",
                              instr_ack, write_addr, constant);
        end
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        flags       = '0;
        mem_ready   = 1'b0;
        test_reset();
        test_add();
        test_lsl();
        test_alu_ops();
        test_load();
        test_store_timeout();
        test_bgt();
        test_branches();
        test_reset_mid_mem();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
